toll_billing_unit: RTL and testbench

- Charging end of the toll-plaza lane controller: consumes the lane FSM's charge request (cobrar) and vehicle-class code (automovel).
- Looks up the fare, adds it to a 4-digit BCD revenue total with a digit-serial adder, and acknowledges with a one-cycle pago pulse.
- Drives the four 7-segment displays: shows the fare after each charge, the running total otherwise.

---
 rtl/toll_billing_unit_if.sv | 29 ++
 rtl/toll_billing_unit.sv | 209 ++++++++++++++++++++
 tb/tb_toll_billing_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/toll_billing_unit_if.sv
// Lane-side bundle between the lane FSM and the billing unit.
// Latency: none (wires only).
// Backpressure: none; cobrar is a level request acknowledged by the pago pulse.
interface toll_billing_unit_if;
    logic        cobrar;
    logic [3:0]  automovel;
    logic        limpar;
    logic        pago;
    logic        erro;
    logic        ovf;
    logic [15:0] total;
    logic [7:0]  contagem;
    logic [0:6]  HEX3;
    logic [0:6]  HEX2;
    logic [0:6]  HEX1;
    logic [0:6]  HEX0;

    // Lane FSM side: issues requests, observes billing results.
    modport master (
        output cobrar, automovel, limpar,
        input  pago, erro, ovf, total, contagem, HEX3, HEX2, HEX1, HEX0
    );

    // Billing unit side.
    modport slave (
        input  cobrar, automovel, limpar,
        output pago, erro, ovf, total, contagem, HEX3, HEX2, HEX1, HEX0
    );
endinterface

// File: rtl/toll_billing_unit.sv
// Fare lookup + digit-serial BCD revenue accumulator with 7-segment display drive.
// Latency: pago pulses in the cycle after the charge edge E + 5 edges (one LOOKUP, four ADD).
// Backpressure: none; one charge per cobrar high period, edges outside IDLE are ignored.
module toll_billing_unit #(
    parameter logic [15:0] FARE_CARRO  = 16'h0550,
    parameter logic [15:0] FARE_CARGA2 = 16'h1100,
    parameter logic [15:0] FARE_CARGA3 = 16'h1650,
    parameter logic [15:0] FARE_CARGA4 = 16'h2200,
    parameter int unsigned SHOW_CYCLES = 8
) (
    input  logic               clock,
    input  logic               resetn,
    toll_billing_unit_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_ADD, S_SHOW, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic        cobrar_q;
    logic [3:0]  class_q, class_d;
    logic [15:0] fare_q, fare_d;
    logic [15:0] total_q, total_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        carry_q, carry_d;
    logic [7:0]  show_q, show_d;
    logic        pago_q, pago_d;
    logic        erro_q, erro_d;
    logic        ovf_q, ovf_d;
    logic [0:6]  hex3_q, hex2_q, hex1_q, hex0_q;
    logic [0:6]  hex3_d, hex2_d, hex1_d, hex0_d;

    logic        chg_evt;
    logic        class_ok;
    logic [15:0] fare_lut;
    logic [4:0]  dsum;
    logic [4:0]  dadj;
    logic [3:0]  dig;
    logic        cout;
    logic [15:0] disp;

    // Segment pattern a..g, active low; anything above 9 blanks the digit.
    function automatic logic [0:6] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign chg_evt = bus.cobrar & ~cobrar_q;

    // Class decode: only the four thermometer codes carry a fare.
    always_comb begin
        class_ok = 1'b1;
        fare_lut = 16'h0000;
        case (class_q)
            4'b1000: fare_lut = FARE_CARRO;
            4'b1100: fare_lut = FARE_CARGA2;
            4'b1110: fare_lut = FARE_CARGA3;
            4'b1111: fare_lut = FARE_CARGA4;
            default: class_ok = 1'b0;
        endcase
    end

    // One BCD digit of total + fare + carry, selected by the digit index.
    always_comb begin
        dsum = {1'b0, total_q[{idx_q, 2'b00} +: 4]} + {1'b0, fare_q[{idx_q, 2'b00} +: 4]} + {4'b0000, carry_q};
        dadj = dsum - 5'd10;
        cout = (dsum > 5'd9);
        dig  = cout ? dadj[3:0] : dsum[3:0];
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (chg_evt) state_d = S_LOOKUP;
            S_LOOKUP: state_d = class_ok ? S_ADD : S_HOLD;
            S_ADD:    if (idx_q == 2'd3) state_d = S_SHOW;
            S_SHOW:   if (show_q == 8'(SHOW_CYCLES - 1)) state_d = S_HOLD;
            S_HOLD:   if (!bus.cobrar) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and output next-state values per state.
    always_comb begin
        class_d = class_q;
        fare_d  = fare_q;
        total_d = total_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        show_d  = show_q;
        pago_d  = 1'b0;
        erro_d  = erro_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                // A charge edge on the same cycle as limpar takes priority.
                if (chg_evt) begin
                    class_d = bus.automovel;
                end else if (bus.limpar) begin
                    total_d = 16'h0000;
                    cnt_d   = 8'd0;
                    ovf_d   = 1'b0;
                end
            end
            S_LOOKUP: begin
                if (class_ok) begin
                    fare_d  = fare_lut;
                    erro_d  = 1'b0;
                    idx_d   = 2'd0;
                    carry_d = 1'b0;
                end else begin
                    erro_d  = 1'b1;
                end
            end
            S_ADD: begin
                total_d[{idx_q, 2'b00} +: 4] = dig;
                carry_d = cout;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    if (cout) begin
                        total_d = 16'h9999;
                        ovf_d   = 1'b1;
                    end
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                    pago_d = 1'b1;
                    show_d = 8'd0;
                end
            end
            S_SHOW: show_d = show_q + 8'd1;
            default: ;
        endcase
    end

    // Display source: fare while showing a charge, running total otherwise.
    always_comb begin
        disp   = (state_q == S_SHOW) ? fare_q : total_q;
        hex3_d = seg7(disp[15:12]);
        hex2_d = seg7(disp[11:8]);
        hex1_d = seg7(disp[7:4]);
        hex0_d = seg7(disp[3:0]);
    end

    // Datapath registers; reset discards any charge in progress.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cobrar_q <= 1'b0;
            class_q  <= 4'd0;
            fare_q   <= 16'h0000;
            total_q  <= 16'h0000;
            cnt_q    <= 8'd0;
            idx_q    <= 2'd0;
            carry_q  <= 1'b0;
            show_q   <= 8'd0;
            pago_q   <= 1'b0;
            erro_q   <= 1'b0;
            ovf_q    <= 1'b0;
            hex3_q   <= 7'b1111111;
            hex2_q   <= 7'b1111111;
            hex1_q   <= 7'b1111111;
            hex0_q   <= 7'b1111111;
        end else begin
            cobrar_q <= bus.cobrar;
            class_q  <= class_d;
            fare_q   <= fare_d;
            total_q  <= total_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            show_q   <= show_d;
            pago_q   <= pago_d;
            erro_q   <= erro_d;
            ovf_q    <= ovf_d;
            hex3_q   <= hex3_d;
            hex2_q   <= hex2_d;
            hex1_q   <= hex1_d;
            hex0_q   <= hex0_d;
        end
    end

    assign bus.pago     = pago_q;
    assign bus.erro     = erro_q;
    assign bus.ovf      = ovf_q;
    assign bus.total    = total_q;
    assign bus.contagem = cnt_q;
    assign bus.HEX3     = hex3_q;
    assign bus.HEX2     = hex2_q;
    assign bus.HEX1     = hex1_q;
    assign bus.HEX0     = hex0_q;

endmodule

// File: tb/tb_toll_billing_unit.sv
// Directed bench for toll_billing_unit: charges, BCD carry, invalid class, saturation, reset.
// Inputs driven and outputs sampled on the falling clock edge.
// Every wait is a fixed cycle count, so the run always ends on its own.
module tb_toll_billing_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    toll_billing_unit_if bus ();

    toll_billing_unit dut (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [27:0] BLANK4 = 28'hFFFFFFF;

    // Expected active-low a..g pattern for one BCD digit.
    function automatic logic [6:0] seg_exp(input logic [3:0] d);
        logic [6:0] tab [0:9];
        tab[0] = 7'b0000001; tab[1] = 7'b1001111; tab[2] = 7'b0010010;
        tab[3] = 7'b0000110; tab[4] = 7'b1001100; tab[5] = 7'b0100100;
        tab[6] = 7'b0100000; tab[7] = 7'b0001111; tab[8] = 7'b0000000;
        tab[9] = 7'b0000100;
        return (d > 4'd9) ? 7'b1111111 : tab[d];
    endfunction

    function automatic logic [27:0] hex_exp(input logic [15:0] v);
        return {seg_exp(v[15:12]), seg_exp(v[11:8]), seg_exp(v[7:4]), seg_exp(v[3:0])};
    endfunction

    function automatic logic [27:0] hex_now();
        return {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // cobrar high 20 cycles with the given class, then low for 4 cycles.
    // first = falling-edge index (1 = right after charge edge E) of first pago.
    task automatic charge(input logic [3:0] cls, output int npago, output int first,
                          output logic [27:0] hex_show, output logic [27:0] hex_hold);
        @(negedge clk);
        bus.cobrar    = 1'b1;
        bus.automovel = cls;
        npago    = 0;
        first    = -1;
        hex_show = '0;
        hex_hold = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.pago) begin
                npago++;
                if (first < 0) first = k;
            end
            if (k == 10) hex_show = hex_now();
            if (k == 18) hex_hold = hex_now();
        end
        bus.cobrar = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.pago) npago++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.cobrar = 1'b0;
        bus.limpar = 1'b0;
        bus.automovel = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    int          np, fi, tot_p;
    logic [27:0] hs, hh;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.cobrar = 1'b0;
        bus.limpar = 1'b0;
        bus.automovel = 4'd0;

        // Reset state, sampled while reset is asserted.
        repeat (3) @(negedge clk);
        chk("rst_pago", 32'(bus.pago), 32'd0);
        chk("rst_erro", 32'(bus.erro), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_total", 32'(bus.total), 32'h0);
        chk("rst_cont", 32'(bus.contagem), 32'd0);
        chk("rst_hex", 32'(hex_now()), 32'(BLANK4));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_hex_zero", 32'(hex_now()), 32'(hex_exp(16'h0000)));

        // Single car charge: pago in the cycle ending at edge E+6.
        charge(4'b1000, np, fi, hs, hh);
        chk("car_npago", 32'(np), 32'd1);
        chk("car_pago_at", 32'(fi), 32'd6);
        chk("car_total", 32'(bus.total), 32'h0550);
        chk("car_cont", 32'(bus.contagem), 32'd1);
        chk("car_hex_fare", 32'(hs), 32'(hex_exp(16'h0550)));

        // BCD carry through every middle digit: 0550 + 0550 = 1100.
        charge(4'b1000, np, fi, hs, hh);
        chk("carry_total", 32'(bus.total), 32'h1100);
        chk("carry_hex_fare", 32'(hs), 32'(hex_exp(16'h0550)));
        chk("carry_hex_hold", 32'(hh), 32'(hex_exp(16'h1100)));
        chk("carry_cont", 32'(bus.contagem), 32'd2);

        // All four classes: 0550 + 1100 + 1650 + 2200 = 5500.
        do_reset();
        tot_p = 0;
        charge(4'b1000, np, fi, hs, hh); tot_p += np;
        charge(4'b1100, np, fi, hs, hh); tot_p += np;
        chk("c2_hex_fare", 32'(hs), 32'(hex_exp(16'h1100)));
        charge(4'b1110, np, fi, hs, hh); tot_p += np;
        charge(4'b1111, np, fi, hs, hh); tot_p += np;
        chk("four_pagos", 32'(tot_p), 32'd4);
        chk("four_total", 32'(bus.total), 32'h5500);
        chk("four_cont", 32'(bus.contagem), 32'd4);
        chk("four_erro", 32'(bus.erro), 32'd0);
        chk("four_ovf", 32'(bus.ovf), 32'd0);

        // Invalid class: flagged, nothing charged; the next valid charge clears it.
        charge(4'b1010, np, fi, hs, hh);
        chk("inv_erro", 32'(bus.erro), 32'd1);
        chk("inv_npago", 32'(np), 32'd0);
        chk("inv_total", 32'(bus.total), 32'h5500);
        chk("inv_cont", 32'(bus.contagem), 32'd4);
        charge(4'b0000, np, fi, hs, hh);
        chk("zero_erro", 32'(bus.erro), 32'd1);
        charge(4'b1000, np, fi, hs, hh);
        chk("inv_clear_erro", 32'(bus.erro), 32'd0);
        chk("inv_next_total", 32'(bus.total), 32'h6050);

        // Saturation: 4 x 2200 = 8800, + 1650 overflows to 9999.
        do_reset();
        for (int v = 0; v < 4; v++) charge(4'b1111, np, fi, hs, hh);
        chk("pre_ovf_total", 32'(bus.total), 32'h8800);
        chk("pre_ovf_flag", 32'(bus.ovf), 32'd0);
        charge(4'b1110, np, fi, hs, hh);
        chk("ovf_npago", 32'(np), 32'd1);
        chk("ovf_total", 32'(bus.total), 32'h9999);
        chk("ovf_flag", 32'(bus.ovf), 32'd1);
        chk("ovf_cont", 32'(bus.contagem), 32'd5);

        // limpar in IDLE clears total, count and overflow.
        @(negedge clk);
        bus.limpar = 1'b1;
        @(negedge clk);
        bus.limpar = 1'b0;
        chk("clr_total", 32'(bus.total), 32'h0);
        chk("clr_ovf", 32'(bus.ovf), 32'd0);
        chk("clr_cont", 32'(bus.contagem), 32'd0);

        // Reset at E+3 mid-ADD, cobrar held high across release.
        charge(4'b1000, np, fi, hs, hh);
        @(negedge clk);
        bus.cobrar    = 1'b1;
        bus.automovel = 4'b1000;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_total", 32'(bus.total), 32'h0);
        chk("mid_rst_cont", 32'(bus.contagem), 32'd0);
        chk("mid_rst_pago", 32'(bus.pago), 32'd0);
        chk("mid_rst_hex", 32'(hex_now()), 32'(BLANK4));
        @(negedge clk);
        rst_n = 1'b1;
        np = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.pago) np++;
        end
        bus.cobrar = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.pago) np++;
        end
        chk("held_npago", 32'(np), 32'd1);
        chk("held_total", 32'(bus.total), 32'h0550);
        chk("held_cont", 32'(bus.contagem), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
